uart_packet_tx: RTL and testbench

//  Transmit-side counterpart of the UART control path. Takes one 32-bit packet plus a

---
 rtl/uart_packet_tx.sv | 185 ++++++++++++++++++
 tb/tb_uart_packet_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: takes one 32-bit packet plus a length code, splits it into
// bytes (LSB first) and feeds them one at a time to a UART byte transmitter
// over a tx_start / tx_done handshake.
// Optional feature macro: UART_PACKET_TX_CHECKSUM_EN appends one extra byte,
// the XOR of all data bytes sent, before pulse_sent.
// The shift register is 32 bits wide, so LEN_BITS above 2 is not meaningful.
module uart_packet_tx #(
  parameter logic [15:0] TIMEOUT  = 16'd50000,  // 0 disables the per-byte timeout
  parameter int          LEN_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  input  logic [31:0] packet,
  input  logic        pulse_packet,
  input  logic [7:0]  configuration,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        pulse_sent,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int              NB_W     = LEN_BITS + 1;
  localparam logic [NB_W-1:0] NB_MAX   = NB_W'(2**LEN_BITS);
  localparam logic [NB_W-1:0] NB_ONE   = NB_W'(1);
  localparam logic [15:0]     TMO_LAST = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;

`ifdef UART_PACKET_TX_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CSUM, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_ABORT} state_t;
`endif

  // accepted request: raw packet and decoded byte count
  typedef struct packed {
    logic [31:0]     data;
    logic [NB_W-1:0] nbytes;
  } pkt_req_t;

  state_t          state, nxt;
  pkt_req_t        req_in;
  logic [31:0]     shift_q;
  logic [NB_W-1:0] nbytes_q;
  logic [NB_W-1:0] cnt_q;
  logic [15:0]     timer_q;
  logic            accept;
  logic            byte_done;
  logic            last_byte;
  logic            more_data;
  logic            timer_run;
  logic            tmo_hit;
  logic [LEN_BITS-1:0] len_code;
  logic            unused_cfg;

`ifdef UART_PACKET_TX_CHECKSUM_EN
  logic [7:0]      csum_q;
  logic            csum_phase_q;   // the byte in flight is the checksum
`endif

  // length code 0 means the full packet width
  assign len_code       = configuration[LEN_BITS-1:0];
  assign req_in.data    = packet;
  assign req_in.nbytes  = (len_code == '0) ? NB_MAX : {1'b0, len_code};
  assign unused_cfg     = ^configuration[7:LEN_BITS];

  assign last_byte = ((cnt_q + NB_ONE) == nbytes_q);
  assign tmo_hit   = (TIMEOUT != 16'd0) && (timer_q >= TMO_LAST);

`ifdef UART_PACKET_TX_CHECKSUM_EN
  assign more_data = byte_done && !last_byte && !csum_phase_q;
  assign timer_run = (state == S_SEND) || (state == S_WAIT) || (state == S_CSUM);
`else
  assign more_data = byte_done && !last_byte;
  assign timer_run = (state == S_SEND) || (state == S_WAIT);
`endif

  // a request outside IDLE is dropped and flagged for that cycle only
  assign overrun = pulse_packet && (state != S_IDLE);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // next-state and strobe decode
  always_comb begin
    nxt         = state;
    tx_start    = 1'b0;
    busy        = 1'b0;
    pulse_sent  = 1'b0;
    timeout_err = 1'b0;
    accept      = 1'b0;
    byte_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pulse_packet) begin
          accept = 1'b1;
          nxt    = S_SEND;
        end
      end
      S_SEND: begin
        tx_start = 1'b1;
        busy     = 1'b1;
        nxt      = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // tx_done takes priority over a timeout expiring in the same cycle
        if (tx_done) begin
          byte_done = 1'b1;
`ifdef UART_PACKET_TX_CHECKSUM_EN
          if (csum_phase_q)   nxt = S_DONE;
          else if (last_byte) nxt = S_CSUM;
          else                nxt = S_SEND;
`else
          nxt = last_byte ? S_DONE : S_SEND;
`endif
        end else if (tmo_hit) begin
          nxt = S_ABORT;
        end
      end
`ifdef UART_PACKET_TX_CHECKSUM_EN
      S_CSUM: begin
        tx_start = 1'b1;
        busy     = 1'b1;
        nxt      = S_WAIT;
      end
`endif
      S_DONE: begin
        busy       = 1'b1;
        pulse_sent = 1'b1;
        nxt        = S_IDLE;
      end
      S_ABORT: begin
        timeout_err = 1'b1;
        nxt         = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // datapath: shift register, byte counter, per-byte timer and tx_data.
  // tx_data is loaded on entry to SEND so it is valid during the tx_start cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= '0;
      nbytes_q     <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      tx_data      <= 8'h00;
`ifdef UART_PACKET_TX_CHECKSUM_EN
      csum_q       <= 8'h00;
      csum_phase_q <= 1'b0;
`endif
    end else if (accept) begin
      shift_q      <= req_in.data;
      nbytes_q     <= req_in.nbytes;
      cnt_q        <= '0;
      timer_q      <= '0;
      tx_data      <= req_in.data[7:0];
`ifdef UART_PACKET_TX_CHECKSUM_EN
      csum_q       <= req_in.data[7:0];
      csum_phase_q <= 1'b0;
`endif
    end else if (byte_done) begin
      shift_q <= shift_q >> 8;
      cnt_q   <= cnt_q + NB_ONE;
      timer_q <= '0;
      if (more_data) tx_data <= shift_q[15:8];
`ifdef UART_PACKET_TX_CHECKSUM_EN
      if (more_data) csum_q <= csum_q ^ shift_q[15:8];
      if (last_byte && !csum_phase_q) begin
        tx_data      <= csum_q;
        csum_phase_q <= 1'b1;
      end
`endif
    end else if (timer_run && (timer_q != 16'hFFFF)) begin
      timer_q <= timer_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: directed scenarios plus random
// packets, compared against a byte-list / cycle-offset reference model.
module tb_uart_packet_tx;

  logic        clk;
  logic        rst;
  logic [31:0] packet;
  logic        pulse_packet;
  logic [7:0]  configuration;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        pulse_sent;
  logic        overrun;
  logic        timeout_err;

  uart_packet_tx #(.TIMEOUT(16'd20), .LEN_BITS(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .packet        (packet),
    .pulse_packet  (pulse_packet),
    .configuration (configuration),
    .tx_done       (tx_done),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .busy          (busy),
    .pulse_sent    (pulse_sent),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;

  ev_t  start_q[$];
  ev_t  sent_q[$];
  ev_t  ovr_q[$];
  ev_t  tmo_q[$];

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   resp_lat = 0;      // tx_done delay after tx_start; 0 = never answer
  logic stray_done = 1'b0;
  logic pend;
  int   due;
  logic [7:0] mon_cur = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    start_q.delete();
    sent_q.delete();
    ovr_q.delete();
    tmo_q.delete();
  endtask

  // UART TX stand-in: answers each tx_start with a one-cycle tx_done
  initial begin
    tx_done = 1'b0;
    pend    = 1'b0;
    due     = 0;
    forever begin
      @(posedge clk);
      #2;
      tx_done = (pend && cyc == due) || stray_done;
      if (pend && cyc == due) pend = 1'b0;
      @(negedge clk);
      if (!rst) pend = 1'b0;
      else if (tx_start && resp_lat > 0) begin
        pend = 1'b1;
        due  = cyc + resp_lat;
      end
    end
  end

  // event recorder, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        start_q.push_back('{cyc, tx_data});
        mon_cur = tx_data;
      end
      if (pulse_sent)  sent_q.push_back('{cyc, 8'(busy)});
      if (overrun)     ovr_q.push_back('{cyc, 8'(pulse_sent)});
      if (timeout_err) tmo_q.push_back('{cyc, 8'(busy)});
      if (tx_done && busy && !tx_start) chk("tx_data_hold", 32'(tx_data), 32'(mon_cur));
    end
  end

  // One packet with a fixed tx_done latency. ov > 0: extra request ov cycles
  // after the accept cycle; ov < 0: extra request during the pulse_sent cycle.
  task automatic run_pkt(input string tag, input logic [31:0] pkt, input logic [7:0] cfg,
                         input int lat, input int ov_in);
    logic [7:0] exp_b[$];
    logic [7:0] x;
    int nb, exp_sent, acc, ov;
    bit done;
    nb = (cfg[1:0] == 2'b00) ? 4 : int'(cfg[1:0]);
    x  = 8'h00;
    for (int k = 0; k < nb; k++) begin
      exp_b.push_back(pkt[8*k +: 8]);
      x = x ^ pkt[8*k +: 8];
    end
`ifdef UART_PACKET_TX_CHECKSUM_EN
    exp_b.push_back(x);
`endif
    exp_sent = 1 + exp_b.size() * (lat + 1);
    ov = (ov_in < 0) ? exp_sent : ov_in;
    clear_q();
    resp_lat = lat;
    step();
    packet = pkt; configuration = cfg; pulse_packet = 1'b1;
    acc = cyc;
    done = 0;
    for (int i = 1; i < 400 && !done; i++) begin
      step();
      pulse_packet = (i == ov);
      if (i == 1) begin
        configuration = 8'($urandom);
        packet = $urandom;
      end
      if (sent_q.size() != 0 || tmo_q.size() != 0) done = 1;
    end
    pulse_packet = 1'b0;
    chk({tag, "_finished"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    repeat (4) step();
    chk({tag, "_nstart"}, start_q.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < start_q.size(); k++) begin
      chk({tag, "_byte"}, 32'(start_q[k].d), 32'(exp_b[k]));
      chk({tag, "_start_cyc"}, start_q[k].c - acc, 1 + k * (lat + 1));
    end
    chk({tag, "_nsent"}, sent_q.size(), 1);
    if (sent_q.size() != 0) begin
      chk({tag, "_sent_cyc"}, sent_q[0].c - acc, exp_sent);
      chk({tag, "_sent_busy"}, 32'(sent_q[0].d), 32'd1);
    end
    chk({tag, "_ntmo"}, tmo_q.size(), 0);
    chk({tag, "_novr"}, ovr_q.size(), (ov != 0) ? 1 : 0);
    if (ov != 0 && ovr_q.size() != 0) begin
      chk({tag, "_ovr_cyc"}, ovr_q[0].c - acc, ov);
      chk({tag, "_ovr_with_sent"}, 32'(ovr_q[0].d), (ov == exp_sent) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int n0, found;
    rst = 1'b0; packet = '0; pulse_packet = 1'b0; configuration = '0;
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulse_sent", 32'(pulse_sent), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    run_pkt("t1", 32'hA1B2C3D4, 8'h00, 10, 0);
    run_pkt("t2", 32'h00000055, 8'h01, 1, 0);
    run_pkt("t3_ovr", 32'h5A6B7C8D, 8'h02, 8, 5);
    run_pkt("t6_ovr_done", 32'h0F1E2D3C, 8'hFF, 3, -1);

    for (int r = 0; r < 8; r++)
      run_pkt("rnd", $urandom, 8'($urandom), int'($urandom_range(1, 16)), 0);

    // timeout: tx_done never comes
    clear_q();
    resp_lat = 0;
    step();
    packet = 32'hCAFEF00D; configuration = 8'h03; pulse_packet = 1'b1;
    step();
    pulse_packet = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (tmo_q.size() != 0 || sent_q.size() != 0) found = 1;
    end
    chk("t4_seen", found, 1);
    repeat (3) step();
    chk("t4_nstart", start_q.size(), 1);
    chk("t4_ntmo", tmo_q.size(), 1);
    chk("t4_nsent", sent_q.size(), 0);
    if (start_q.size() == 1 && tmo_q.size() == 1) begin
      chk("t4_latency", tmo_q[0].c - start_q[0].c, 20);
      chk("t4_busy", 32'(tmo_q[0].d), 32'd0);
    end
    run_pkt("t4_next", 32'h13579BDF, 8'h00, 2, 0);

    // asynchronous reset in the middle of byte 2
    clear_q();
    resp_lat = 10;
    step();
    packet = 32'h11223344; configuration = 8'h00; pulse_packet = 1'b1;
    step();
    pulse_packet = 1'b0;
    for (int i = 0; i < 100 && start_q.size() < 2; i++) step();
    chk("t5_byte2_started", start_q.size(), 2);
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    chk("t5_tx_data", 32'(tx_data), 32'd0);
    chk("t5_tx_start", 32'(tx_start), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pulse_sent", 32'(pulse_sent), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    chk("t5_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    n0 = start_q.size();
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (4) step();
    chk("t5_stray_ignored", start_q.size(), n0);
    chk("t5_no_sent", sent_q.size() + tmo_q.size(), 0);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 32'd0);
    run_pkt("t5_new", 32'h11223344, 8'h00, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
